// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : 16-bit program counter. It drives and loads the shared
//                address bus (abus), increments for fetch, and loads/stores
//                byte-serially over the 8-bit main bus (mbus), low byte first.
//                A byte-serial load commits both bytes in one edge, so abus
//                never shows a half-updated counter.
//                Optional build macro: PC_WRAP_FLAG_EN adds a registered
//                one-cycle 'wrap' pulse after an increment 0xFFFF -> 0x0000.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] abus,
    inout  wire  [7:0]  mbus,
    input  logic        outn,
    input  logic        loadn,
    input  logic        incn,
    input  logic        lbn,
    input  logic        obn,
    output logic [15:0] value,
    output logic        ld_phase,
    output logic        out_phase
`ifdef PC_WRAP_FLAG_EN
    ,
    output logic        wrap
`endif
);

    // Byte-load sequencer: LD_LO expects the low byte, LD_HI the high byte.
    typedef enum logic [0:0] {
        LD_LO = 1'b0,
        LD_HI = 1'b1
    } ld_state_t;

    // Byte-output sequencer: OUT_LO shows value[7:0], OUT_HI the snapshot.
    typedef enum logic [0:0] {
        OUT_LO = 1'b0,
        OUT_HI = 1'b1
    } out_state_t;

    ld_state_t   r_ld_state;
    ld_state_t   w_ld_state_next;
    out_state_t  r_out_state;
    out_state_t  w_out_state_next;
    logic [15:0] r_value;
    logic [15:0] w_value_next;
    logic [7:0]  r_stage;
    logic [7:0]  w_stage_next;
    logic [7:0]  r_snap;
    logic [7:0]  w_snap_next;
    logic        w_commit;
    logic [7:0]  w_mbus_byte;

    // Next-state for counter, staging byte, snapshot and both sequencers.
    // Priority: loadn > byte commit > increment (reset handled in the register).
    always_comb begin
        w_value_next     = r_value;
        w_stage_next     = r_stage;
        w_snap_next      = r_snap;
        w_ld_state_next  = r_ld_state;
        w_out_state_next = r_out_state;
        w_commit         = 1'b0;

        if (!loadn) begin
            // Parallel load aborts any byte sequence in progress.
            w_value_next     = abus;
            w_ld_state_next  = LD_LO;
            w_out_state_next = OUT_LO;
        end else begin
            if (!lbn) begin
                if (r_ld_state == LD_LO) begin
                    w_stage_next    = mbus;
                    w_ld_state_next = LD_HI;
                end else begin
                    w_commit        = 1'b1;
                    w_value_next    = {mbus, r_stage};
                    w_ld_state_next = LD_LO;
                end
            end

            if (!w_commit && !incn) begin
                w_value_next = r_value + 16'd1;
            end

            // Output sequencer only steps when it actually owns mbus.
            if (!obn && lbn) begin
                if (r_out_state == OUT_LO) begin
                    w_snap_next      = r_value[15:8];
                    w_out_state_next = OUT_HI;
                end else begin
                    w_out_state_next = OUT_LO;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_value     <= RESET_VECTOR;
            r_stage     <= 8'h00;
            r_snap      <= 8'h00;
            r_ld_state  <= LD_LO;
            r_out_state <= OUT_LO;
        end else begin
            r_value     <= w_value_next;
            r_stage     <= w_stage_next;
            r_snap      <= w_snap_next;
            r_ld_state  <= w_ld_state_next;
            r_out_state <= w_out_state_next;
        end
    end

`ifdef PC_WRAP_FLAG_EN
    logic r_wrap;
    logic w_wrap_next;

    // Wrap pulse: only a real increment out of 0xFFFF sets it; loads never do.
    always_comb begin
        w_wrap_next = loadn && !w_commit && !incn && (r_value == 16'hFFFF);
    end

    // Registered wrap flag, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    assign wrap = r_wrap;
`endif

    assign value     = r_value;
    assign ld_phase  = (r_ld_state == LD_HI);
    assign out_phase = (r_out_state == OUT_HI);

    // Bus drivers are purely combinational and independent of reset.
    assign w_mbus_byte = (r_out_state == OUT_HI) ? r_snap : r_value[7:0];
    assign abus        = outn ? 16'bz : r_value;
    assign mbus        = (!obn && lbn) ? w_mbus_byte : 8'bz;

endmodule
`default_nettype wire
